hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage ARM core.
- Decides each cycle whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold or take a bubble.
- Covers load-use hazards, which forwarding cannot resolve, taken-branch squashes, multi-cycle multiply occupancy of EX, and data-memory wait states.
- Sits beside the forwarding unit and drives the pipeline-register enables and flushes. Includes a saturating stall-cycle counter.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 30 +++
 rtl/hazard_stall_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encoding, the per-stage enable/flush bundle and the zero-register index.
package hazard_pkg;

    // Sequencer states. Kept as plain constants so the encoding stays fixed
    // for any logic or checkers that probe the state register directly.
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    // Architectural register that never carries a real dependency.
    localparam logic [3:0] REG_ZERO = 4'd0;

    // One write-enable / flush pair per pipeline boundary.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic exmem_flush;
        logic memwb_flush;
    } stage_ctrl_t;

    // Free-running pipeline: every stage advances, nothing is squashed.
    localparam stage_ctrl_t CTRL_ADVANCE = 8'b1101_0100;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: the instruction in ID reads a register
// that the load currently in EX has not yet fetched from memory.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter bit IGNORE_R0 = 1'b1
) (
    input  logic [3:0] rn_id,
    input  logic [3:0] rm_id,
    input  logic       use_rn_id,
    input  logic       use_rm_id,
    input  logic [3:0] rd_idex,
    input  logic       mem_read_idex,
    output logic       loaduse
);

    logic rd_counts;
    logic rn_hit;
    logic rm_hit;

    // A load into r0 never creates a dependency when r0 is ignored, matching
    // the forwarding unit which also never forwards r0.
    assign rd_counts = !IGNORE_R0 || (rd_idex != REG_ZERO);
    assign rn_hit    = use_rn_id && (rd_idex == rn_id);
    assign rm_hit    = use_rm_id && (rd_idex == rm_id);

    // Hazard only when the EX instruction is a load and a used source matches.
    assign loaduse = mem_read_idex && rd_counts && (rn_hit || rm_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core. Each cycle decides
// whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold or take a bubble,
// covering data-memory wait states, multi-cycle multiplies occupying EX,
// taken-branch squashes and load-use hazards. Also counts PC-stall cycles.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT   = 3,
    parameter bit          IGNORE_R0 = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       rn_id,
    input  logic [3:0]       rm_id,
    input  logic             use_rn_id,
    input  logic             use_rm_id,
    input  logic [3:0]       rd_idex,
    input  logic             mem_read_idex,
    input  logic             mul_start_ex,
    input  logic             branch_taken_ex,
    input  logic             mem_req_exmem,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    // Counter only needs to hold MUL_LAT-1.
    localparam int unsigned MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [MC_W-1:0] mul_cnt_q;
    logic [MC_W-1:0] mul_cnt_d;
    logic            memstall;
    logic            loaduse;
    logic            in_mul;
    logic            mul_exit;
    logic            mul_hold;
    stage_ctrl_t     ctrl;

    assign memstall = mem_req_exmem && !dmem_ready;
    assign in_mul   = (state_q == ST_MUL_BUSY);

    // The exit cycle is the last MUL_BUSY cycle: the multiply result is
    // written into EX/MEM and the state is RUN from the next cycle on. If the
    // counter ran out under a memory stall, the exit waits for memstall to clear.
    assign mul_exit = in_mul && !memstall && (mul_cnt_q <= MC_W'(1));
    assign mul_hold = in_mul && !mul_exit;

    load_use_detect #(
        .IGNORE_R0(IGNORE_R0)
    ) u_load_use_detect (
        .rn_id        (rn_id),
        .rm_id        (rm_id),
        .use_rn_id    (use_rn_id),
        .use_rm_id    (use_rm_id),
        .rd_idex      (rd_idex),
        .mem_read_idex(mem_read_idex),
        .loaduse      (loaduse)
    );

    // Prioritised stage control: memory wait, multiply occupancy, branch
    // squash, load-use bubble, then free-running advance.
    always_comb begin
        ctrl = CTRL_ADVANCE;
        if (!rst_n) begin
            ctrl = CTRL_ADVANCE;
        end else if (memstall) begin
            ctrl.pc_we       = 1'b0;
            ctrl.ifid_we     = 1'b0;
            ctrl.idex_we     = 1'b0;
            ctrl.exmem_we    = 1'b0;
            ctrl.memwb_flush = 1'b1;
        end else if (mul_hold) begin
            // EX still owns the multiply, so a branch resolving there is moot.
            ctrl.pc_we       = 1'b0;
            ctrl.ifid_we     = 1'b0;
            ctrl.idex_we     = 1'b0;
            ctrl.exmem_we    = 1'b0;
            ctrl.exmem_flush = 1'b1;
        end else if (branch_taken_ex) begin
            // The ID instruction is squashed, so any load-use on it is dropped.
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (loaduse) begin
            ctrl.pc_we      = 1'b0;
            ctrl.ifid_we    = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    assign pc_we       = ctrl.pc_we;
    assign ifid_we     = ctrl.ifid_we;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_we     = ctrl.idex_we;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_we    = ctrl.exmem_we;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign mul_busy    = in_mul && rst_n;

    // Next-state logic: multiply occupancy counter keeps running under memory
    // stalls; a multiply cannot start while the memory stage is stalled.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mul_start_ex && !memstall) begin
                    state_d   = ST_MUL_BUSY;
                    mul_cnt_d = MC_W'(MUL_LAT - 1);
                end
            end
            ST_MUL_BUSY: begin
                if (mul_cnt_q != '0) begin
                    mul_cnt_d = mul_cnt_q - MC_W'(1);
                end
                if (mul_exit) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_RUN;
                mul_cnt_d = '0;
            end
        endcase
    end

    // State and multiply counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (!ctrl.pc_we && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a table of per-cycle stimulus with the
// expected control vector and stall count for each cycle.
module tb_hazard_stall_ctrl;

    localparam int unsigned CNT_W = 16;

    // Expected control vector bit order:
    // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
    //  exmem_we, exmem_flush, memwb_flush, mul_busy}
    localparam logic [8:0] E_RUN  = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] E_LU   = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] E_BR   = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] E_MH   = 9'b0_0_0_0_0_0_1_0_1;
    localparam logic [8:0] E_MX   = 9'b1_1_0_1_0_1_0_0_1;
    localparam logic [8:0] E_MS0  = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] E_MS1  = 9'b0_0_0_0_0_0_0_1_1;
    localparam logic [8:0] E_LUMX = 9'b0_0_0_1_1_1_0_0_1;

    logic             clk;
    logic             rst_n;
    logic [3:0]       rn_id;
    logic [3:0]       rm_id;
    logic             use_rn_id;
    logic             use_rm_id;
    logic [3:0]       rd_idex;
    logic             mem_read_idex;
    logic             mul_start_ex;
    logic             branch_taken_ex;
    logic             mem_req_exmem;
    logic             dmem_ready;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_count;

    logic [8+CNT_W:0] exp_q[$];
    int               tests_run;
    int               tests_failed;

    hazard_stall_ctrl #(
        .MUL_LAT  (3),
        .IGNORE_R0(1'b1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rn_id          (rn_id),
        .rm_id          (rm_id),
        .use_rn_id      (use_rn_id),
        .use_rm_id      (use_rm_id),
        .rd_idex        (rd_idex),
        .mem_read_idex  (mem_read_idex),
        .mul_start_ex   (mul_start_ex),
        .branch_taken_ex(branch_taken_ex),
        .mem_req_exmem  (mem_req_exmem),
        .dmem_ready     (dmem_ready),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .idex_we        (idex_we),
        .idex_flush     (idex_flush),
        .exmem_we       (exmem_we),
        .exmem_flush    (exmem_flush),
        .memwb_flush    (memwb_flush),
        .mul_busy       (mul_busy),
        .stall_count    (stall_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the current outputs.
    task automatic score(input string tag);
        logic [8+CNT_W:0] e;
        logic [8:0]       obs;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e   = exp_q.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                   exmem_we, exmem_flush, memwb_flush, mul_busy};
            check_eq({tag, ".ctl"}, 32'(obs), 32'(e[8+CNT_W:CNT_W]));
            check_eq({tag, ".cnt"}, 32'(stall_count), 32'(e[CNT_W-1:0]));
        end
    endtask

    task automatic idle_inputs();
        rn_id           = 4'($urandom_range(1, 15));
        rm_id           = 4'($urandom_range(1, 15));
        use_rn_id       = 1'b0;
        use_rm_id       = 1'b0;
        rd_idex         = 4'($urandom_range(0, 15));
        mem_read_idex   = 1'b0;
        mul_start_ex    = 1'b0;
        branch_taken_ex = 1'b0;
        mem_req_exmem   = 1'($urandom_range(0, 1));
        dmem_ready      = 1'b1;
    endtask

    // One cycle: drive inputs after the edge, record the expectation, then
    // score it at the falling edge.
    task automatic step(input string tag,
                        input logic [3:0] rn, input logic [3:0] rm,
                        input logic urn, input logic urm,
                        input logic [3:0] rd, input logic mrd,
                        input logic mul, input logic br,
                        input logic mreq, input logic rdy,
                        input logic [8:0] exp_ctl, input logic [CNT_W-1:0] exp_cnt);
        @(posedge clk);
        #1;
        rn_id           = rn;
        rm_id           = rm;
        use_rn_id       = urn;
        use_rm_id       = urm;
        rd_idex         = rd;
        mem_read_idex   = mrd;
        mul_start_ex    = mul;
        branch_taken_ex = br;
        mem_req_exmem   = mreq;
        dmem_ready      = rdy;
        exp_q.push_back({exp_ctl, exp_cnt});
        @(negedge clk);
        score(tag);
    endtask

    // Stimulus
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        exp_q.push_back({E_RUN, 16'd0});
        score("reset");
        rst_n = 1'b1;

        //   tag         rn     rm     urn  urm  rd     mrd  mul  br   mreq rdy  ctl     cnt
        step("idle0",    4'd1,  4'd2,  1,   1,   4'd9,  0,   0,   0,   0,   1,   E_RUN,  16'd0);
        step("lu_rn",    4'd3,  4'd2,  1,   1,   4'd3,  1,   0,   0,   0,   1,   E_LU,   16'd0);
        step("lu_after", 4'd3,  4'd2,  1,   1,   4'd3,  0,   0,   0,   0,   1,   E_RUN,  16'd1);
        step("lu_r0",    4'd0,  4'd0,  1,   1,   4'd0,  1,   0,   0,   0,   1,   E_RUN,  16'd1);
        step("lu_rm",    4'd6,  4'd5,  1,   1,   4'd5,  1,   0,   0,   0,   1,   E_LU,   16'd1);
        step("lu_unused",4'd7,  4'd8,  0,   1,   4'd7,  1,   0,   0,   0,   1,   E_RUN,  16'd2);
        step("br_lu",    4'd4,  4'd1,  1,   0,   4'd4,  1,   0,   1,   0,   1,   E_BR,   16'd2);
        step("idle1",    4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   0,   1,   1,   E_RUN,  16'd2);
        step("mul_go",   4'd1,  4'd2,  0,   0,   4'd4,  0,   1,   0,   0,   1,   E_RUN,  16'd2);
        step("mul_hold", 4'd2,  4'd2,  1,   0,   4'd2,  1,   0,   1,   0,   1,   E_MH,   16'd2);
        step("mul_exit", 4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   0,   0,   1,   E_MX,   16'd3);
        step("mul_run",  4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   0,   0,   1,   E_RUN,  16'd3);
        step("mul_blk",  4'd1,  4'd2,  0,   0,   4'd4,  0,   1,   0,   1,   0,   E_MS0,  16'd3);
        step("mul_go2",  4'd1,  4'd2,  0,   0,   4'd4,  0,   1,   0,   1,   1,   E_RUN,  16'd4);
        step("ms1",      4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   1,   1,   0,   E_MS1,  16'd4);
        step("ms2",      4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   0,   1,   0,   E_MS1,  16'd5);
        step("ms3",      4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   0,   1,   0,   E_MS1,  16'd6);
        step("ms4",      4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   0,   1,   0,   E_MS1,  16'd7);
        step("ms_exit",  4'd2,  4'd2,  1,   0,   4'd2,  1,   0,   0,   1,   1,   E_LUMX, 16'd8);
        step("ms_run",   4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   0,   0,   1,   E_RUN,  16'd9);
        step("mul_go3",  4'd1,  4'd2,  0,   0,   4'd4,  0,   1,   0,   0,   1,   E_RUN,  16'd9);
        step("mul_hold3",4'd1,  4'd2,  0,   0,   4'd4,  0,   0,   0,   0,   1,   E_MH,   16'd9);

        // Asynchronous reset in the middle of a multiply, away from any edge.
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back({E_RUN, 16'd0});
        score("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 4'd1, 4'd2, 0, 0, 4'd4, 0, 0, 0, 0, 1, E_RUN, 16'd0);
        step("post_rst2",4'd1, 4'd2, 0, 0, 4'd4, 0, 0, 0, 0, 1, E_RUN, 16'd0);

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
